// File: rtl/class_mem_reader_if.sv
// rtl/class_mem_reader_if.sv - control, memory-read and row-stream signals of the class memory reader
// master: the reader itself; slave: the loader, class memory and similarity datapath around it.
interface class_mem_reader_if #(
  parameter int FTWIDTH    = 8,
  parameter int M_SIZE     = 16,
  parameter int DIM        = 4000,
  parameter int ADDR_WIDTH = 13,
  parameter int ROW_W      = $clog2(DIM / M_SIZE)
);
  logic                        start;
  logic [4:0]                  class_num;
  logic                        write_done;
  logic [ADDR_WIDTH-1:0]       read_address;
  logic                        re;
  logic [M_SIZE*FTWIDTH-1:0]   class_out;
  logic [M_SIZE*FTWIDTH-1:0]   out_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [4:0]                  out_class;
  logic [ROW_W-1:0]            out_row;
  logic                        out_last_row;
  logic                        out_last;
  logic                        busy;
  logic                        done;

  modport master (
    input  start, class_num, write_done, class_out, out_ready,
    output read_address, re, out_data, out_valid, out_class, out_row,
           out_last_row, out_last, busy, done
  );

  modport slave (
    output start, class_num, write_done, class_out, out_ready,
    input  read_address, re, out_data, out_valid, out_class, out_row,
           out_last_row, out_last, busy, done
  );
endinterface

// File: rtl/class_mem_reader.sv
// rtl/class_mem_reader.sv - row-by-row read sequencer for the banked class hypervector memory
// Issues credit-limited reads, captures 1-cycle-latency data into a 2-entry FIFO and streams tagged rows.
module class_mem_reader #(
  parameter int FTWIDTH    = 8,
  parameter int M_SIZE     = 16,
  parameter int DIM        = 4000,
  parameter int MAX_CLASS  = 26,
  parameter int ADDR_WIDTH = 13,
  parameter int ROW_W      = $clog2(DIM / M_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  class_mem_reader_if.master   bus
);

  localparam int ROWS = DIM / M_SIZE;
  localparam int DW   = M_SIZE * FTWIDTH;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                r_state;
  logic [4:0]            r_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [4:0]            r_iss_class;
  logic [ROW_W-1:0]      r_iss_row;

  logic                  r_pipe;
  logic [4:0]            r_pipe_class;
  logic [ROW_W-1:0]      r_pipe_row;

  logic [DW-1:0]         r_fifo_data  [2];
  logic [4:0]            r_fifo_class [2];
  logic [ROW_W-1:0]      r_fifo_row   [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_count;

  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_outstanding;
  logic [1:0]            w_count_next;
  logic                  w_re;
  logic                  w_last_issue;
  logic                  w_start_ok;
  logic [4:0]            w_clamp_n;
  logic [4:0]            w_head_class;
  logic [ROW_W-1:0]      w_head_row;

  assign w_valid      = reset & (r_count != 2'd0);
  assign w_pop        = w_valid & bus.out_ready;
  assign w_count_next = r_count + {1'b0, r_pipe} - {1'b0, w_pop};

  // Credit counts the beat leaving this cycle as freed, so a full-rate stream never stalls.
  assign w_outstanding = {1'b0, r_count} + {2'b00, r_pipe} - {2'b00, w_pop};
  assign w_re          = reset & (r_state == S_ISSUE) & (w_outstanding < 3'd2);

  assign w_last_issue = (r_iss_class == r_n - 5'd1) & (r_iss_row == LAST_ROW);
  assign w_start_ok   = bus.start & bus.write_done;
  assign w_clamp_n    = (bus.class_num > 5'(MAX_CLASS)) ? 5'(MAX_CLASS) : bus.class_num;

  assign w_head_class = r_fifo_class[r_rp];
  assign w_head_row   = r_fifo_row[r_rp];

  assign bus.re           = w_re;
  assign bus.read_address = reset ? r_addr : '0;
  assign bus.out_valid    = w_valid;
  assign bus.out_data     = w_valid ? r_fifo_data[r_rp] : '0;
  assign bus.out_class    = w_valid ? w_head_class : 5'd0;
  assign bus.out_row      = w_valid ? w_head_row : '0;
  assign bus.out_last_row = w_valid & (w_head_row == LAST_ROW);
  assign bus.out_last     = w_valid & (w_head_row == LAST_ROW) & (w_head_class == r_n - 5'd1);
  assign bus.busy         = reset & (r_state != S_IDLE);
  assign bus.done         = reset & (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_n         <= 5'd0;
      r_addr      <= '0;
      r_iss_class <= 5'd0;
      r_iss_row   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_n         <= w_clamp_n;
            r_addr      <= '0;
            r_iss_class <= 5'd0;
            r_iss_row   <= '0;
            r_state     <= (w_clamp_n == 5'd0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_re) begin
            // The final address is left on the bus; nothing advances past the last row.
            if (w_last_issue) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr <= r_addr + 1'b1;
              if (r_iss_row == LAST_ROW) begin
                r_iss_row   <= '0;
                r_iss_class <= r_iss_class + 5'd1;
              end else begin
                r_iss_row <= r_iss_row + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_count_next == 2'd0) r_state <= S_DONE;
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pipe       <= 1'b0;
      r_pipe_class <= 5'd0;
      r_pipe_row   <= '0;
      r_wp         <= 1'b0;
      r_rp         <= 1'b0;
      r_count      <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i]  <= '0;
        r_fifo_class[i] <= 5'd0;
        r_fifo_row[i]   <= '0;
      end
    end else begin
      r_pipe       <= w_re;
      r_pipe_class <= r_iss_class;
      r_pipe_row   <= r_iss_row;
      if (r_pipe) begin
        r_fifo_data[r_wp]  <= bus.class_out;
        r_fifo_class[r_wp] <= r_pipe_class;
        r_fifo_row[r_wp]   <= r_pipe_row;
        r_wp               <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_count <= w_count_next;
    end
  end

endmodule
